// File: rtl/aidc_lite_pkg.sv
// Shared types, sizes and helpers for the AIDC-Lite transfer sequencer.
package aidc_lite_pkg;

  localparam int unsigned BLK_BYTES = 128;
  localparam int unsigned BLK_SHIFT = 7;
  localparam int unsigned ADDR_W    = 32;
  localparam int unsigned SIZE_W    = 8;
  localparam int unsigned OUT_W     = 4;   // outstanding-block counter, MAX_OUT <= 15

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  typedef logic [24:0] blk_cnt_t;

  // Round an address down to its 128-byte block base.
  function automatic logic [ADDR_W-1:0] blk_align(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:BLK_SHIFT], {BLK_SHIFT{1'b0}}};
  endfunction

  // A compressed block is 1..128 bytes; anything else is a protocol error.
  function automatic logic size_ok(input logic [SIZE_W-1:0] size);
    return (size != '0) && (size <= SIZE_W'(BLK_BYTES));
  endfunction

endpackage

// File: rtl/aidc_lite_credit_cnt.sv
// Outstanding-block counter: up on issue, down on completion, limited to MAX_OUT.
module aidc_lite_credit_cnt
  import aidc_lite_pkg::*;
#(
  parameter int unsigned MAX_OUT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [OUT_W-1:0] cnt_o,
  output logic             has_credit_c_o
);

  logic [OUT_W-1:0] cnt_q, cnt_d;

  // Next count; simultaneous inc/dec cancel, decrement never underflows.
  // has_credit_c_o reflects the count after this edge so the caller can
  // register a request valid without a bubble.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !dec_i) begin
      cnt_d = cnt_q + OUT_W'(1);
    end else if (!inc_i && dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - OUT_W'(1);
    end
    has_credit_c_o = (cnt_d < OUT_W'(MAX_OUT));
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/aidc_lite_comp_ctrl.sv
// AIDC-Lite transfer sequencer: issues 128B block reads under a credit
// limit and accumulates compressed sizes into the packed write pointer.
module aidc_lite_comp_ctrl
  import aidc_lite_pkg::*;
#(
  parameter int unsigned MAX_OUT = 4,
  parameter int unsigned CNT_W   = 25
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] src_addr_i,
  input  logic [ADDR_W-1:0] dst_addr_i,
  input  logic [CNT_W-1:0]  len_i,
  input  logic              start_i,
  output logic              done_o,
  output logic              rd_req_valid_o,
  input  logic              rd_req_ready_i,
  output logic [ADDR_W-1:0] rd_req_addr_o,
  input  logic              blk_done_i,
  input  logic [SIZE_W-1:0] blk_size_i,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [ADDR_W-1:0] comp_bytes_o
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  blk_total_q, blk_total_d;
  logic [CNT_W-1:0]  issued_q, issued_d;
  logic [CNT_W-1:0]  completed_q, completed_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_W-1:0] comp_q, comp_d;
  logic              done_q, done_d;
  logic              valid_q, valid_d;

  logic              hs_c;
  logic              blk_ok_c;
  logic              start_go_c;
  logic [OUT_W-1:0]  out_cnt;
  logic              has_credit_c;

  // Outstanding-block credit tracking.
  aidc_lite_credit_cnt #(
    .MAX_OUT(MAX_OUT)
  ) u_credit (
    .clk           (clk),
    .rst           (rst),
    .clr_i         (start_go_c),
    .inc_i         (hs_c),
    .dec_i         (blk_ok_c),
    .cnt_o         (out_cnt),
    .has_credit_c_o(has_credit_c)
  );

  // Next-state, address generation and byte accounting.
  always_comb begin
    state_d     = state_q;
    blk_total_d = blk_total_q;
    issued_d    = issued_q;
    completed_d = completed_q;
    rd_ptr_d    = rd_ptr_q;
    wr_addr_d   = wr_addr_q;
    comp_d      = comp_q;
    done_d      = done_q;
    valid_d     = 1'b0;

    hs_c       = valid_q && rd_req_ready_i;
    start_go_c = (state_q == IDLE) && start_i;
    // Malformed completions are dropped without side effects.
    blk_ok_c   = blk_done_i && (state_q != IDLE) && (out_cnt != '0) && size_ok(blk_size_i);

    if (blk_ok_c) begin
      completed_d = completed_q + CNT_W'(1);
      wr_addr_d   = wr_addr_q + ADDR_W'(blk_size_i);
      comp_d      = comp_q + ADDR_W'(blk_size_i);
    end

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          blk_total_d = len_i;
          rd_ptr_d    = blk_align(src_addr_i);
          wr_addr_d   = dst_addr_i;
          comp_d      = '0;
          issued_d    = '0;
          completed_d = '0;
          // Empty job finishes immediately without leaving IDLE.
          done_d      = (len_i == '0);
          state_d     = (len_i == '0) ? IDLE : RUN;
        end
      end
      RUN: begin
        if (hs_c) begin
          issued_d = issued_q + CNT_W'(1);
          rd_ptr_d = rd_ptr_q + ADDR_W'(BLK_BYTES);
          if (issued_d == blk_total_q) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (completed_d == blk_total_q) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A pending request holds until accepted; otherwise re-arm when work and credit remain.
    if (state_d == RUN) begin
      valid_d = (valid_q && !hs_c) || ((issued_d < blk_total_d) && has_credit_c);
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      blk_total_q <= '0;
      issued_q    <= '0;
      completed_q <= '0;
      rd_ptr_q    <= '0;
      wr_addr_q   <= '0;
      comp_q      <= '0;
      done_q      <= 1'b0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      blk_total_q <= blk_total_d;
      issued_q    <= issued_d;
      completed_q <= completed_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_addr_q   <= wr_addr_d;
      comp_q      <= comp_d;
      done_q      <= done_d;
      valid_q     <= valid_d;
    end
  end

  assign done_o         = done_q;
  assign rd_req_valid_o = valid_q;
  assign rd_req_addr_o  = rd_ptr_q;
  assign wr_addr_o      = wr_addr_q;
  assign comp_bytes_o   = comp_q;

  // Completion interface protocol checks.
  a_done_ctx : assert property (@(posedge clk) disable iff (rst)
    blk_done_i |-> ((state_q != IDLE) && (out_cnt != '0)));
  a_done_size : assert property (@(posedge clk) disable iff (rst)
    blk_done_i |-> size_ok(blk_size_i));

endmodule

// File: tb/tb_aidc_lite_comp_ctrl.sv
// Scoreboard bench for aidc_lite_comp_ctrl: expected read addresses are
// queued by the stimulus and checked by a handshake monitor.
module tb_aidc_lite_comp_ctrl;
  import aidc_lite_pkg::*;

  localparam int unsigned MAX_OUT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] src_addr_i, dst_addr_i;
  blk_cnt_t    len_i;
  logic        start_i;
  logic        done_o;
  logic        rd_req_valid_o;
  logic        rd_req_ready_i;
  logic [31:0] rd_req_addr_o;
  logic        blk_done_i;
  logic [7:0]  blk_size_i;
  logic [31:0] wr_addr_o;
  logic [31:0] comp_bytes_o;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          hs_cnt = 0;
  int          cyc = 0;
  bit          auto_en = 1'b0;
  logic [7:0]  auto_size = 8'd0;
  logic [7:0]  man_size = 8'd0;
  int          man_req = 0;
  int          man_ack = 0;
  logic [31:0] exp_addr_q[$];
  int          pend_q[$];
  int          hs0;

  aidc_lite_comp_ctrl #(.MAX_OUT(MAX_OUT), .CNT_W(25)) dut (
    .clk           (clk),
    .rst           (rst),
    .src_addr_i    (src_addr_i),
    .dst_addr_i    (dst_addr_i),
    .len_i         (len_i),
    .start_i       (start_i),
    .done_o        (done_o),
    .rd_req_valid_o(rd_req_valid_o),
    .rd_req_ready_i(rd_req_ready_i),
    .rd_req_addr_o (rd_req_addr_o),
    .blk_done_i    (blk_done_i),
    .blk_size_i    (blk_size_i),
    .wr_addr_o     (wr_addr_o),
    .comp_bytes_o  (comp_bytes_o)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [31:0] s, input logic [31:0] d, input blk_cnt_t l);
    src_addr_i = s;
    dst_addr_i = d;
    len_i      = l;
    start_i    = 1'b1;
    tick(1);
    start_i    = 1'b0;
  endtask

  task automatic wait_done(input string name, input int max_cyc);
    int i = 0;
    while (!done_o && i < max_cyc) begin
      tick(1);
      i++;
    end
    chk(name, 32'(done_o), 32'd1);
  endtask

  task automatic man_pulse(input logic [7:0] size);
    man_size = size;
    man_req++;
  endtask

  // Completion responder: sole driver of blk_done_i/blk_size_i.
  initial begin
    blk_done_i = 1'b0;
    blk_size_i = 8'd0;
    forever begin
      @(posedge clk);
      #2;
      blk_done_i = 1'b0;
      if (auto_en && pend_q.size() > 0 && pend_q[0] <= cyc) begin
        void'(pend_q.pop_front());
        blk_done_i = 1'b1;
        blk_size_i = auto_size;
      end else if (man_req != man_ack) begin
        man_ack++;
        blk_done_i = 1'b1;
        blk_size_i = man_size;
      end
    end
  end

  // Handshake monitor: pops the expected address for every accepted request.
  initial begin
    logic [31:0] exp;
    forever begin
      @(negedge clk);
      if (!rst && rd_req_valid_o && rd_req_ready_i) begin
        hs_cnt++;
        n_cmp++;
        if (exp_addr_q.size() == 0) begin
          n_bad++;
          $display("FAIL rd_addr: unexpected request at 0x%08h, none expected", rd_req_addr_o);
        end else begin
          exp = exp_addr_q.pop_front();
          if (rd_req_addr_o !== exp) begin
            n_bad++;
            $display("FAIL rd_addr: got 0x%08h expected 0x%08h", rd_req_addr_o, exp);
          end
        end
        if (auto_en) pend_q.push_back(cyc + 2);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst            = 1'b1;
    start_i        = 1'b0;
    src_addr_i     = '0;
    dst_addr_i     = '0;
    len_i          = '0;
    rd_req_ready_i = 1'b0;
    tick(3);
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_done",  32'(done_o), 32'd0);
    chk("rst_valid", 32'(rd_req_valid_o), 32'd0);
    chk("rst_addr",  rd_req_addr_o, 32'd0);
    chk("rst_wr",    wr_addr_o, 32'd0);
    chk("rst_comp",  comp_bytes_o, 32'd0);
    @(posedge clk); #1;

    // Basic job
    auto_en = 1'b1; auto_size = 8'd64; rd_req_ready_i = 1'b1;
    exp_addr_q.push_back(32'h1000_0000);
    exp_addr_q.push_back(32'h1000_0080);
    exp_addr_q.push_back(32'h1000_0100);
    hs0 = hs_cnt;
    start_job(32'h1000_0040, 32'h2000_0003, 25'd3);
    wait_done("basic_done", 100);
    chk("basic_wr",   wr_addr_o, 32'h2000_00C3);
    chk("basic_comp", comp_bytes_o, 32'd192);
    chk("basic_hs",   32'(hs_cnt - hs0), 32'd3);
    chk("basic_q",    32'(exp_addr_q.size()), 32'd0);
    auto_en = 1'b0;

    // Credit limit
    for (int i = 0; i < 8; i++) exp_addr_q.push_back(32'h4000_0000 + 32'(i * 128));
    hs0 = hs_cnt;
    start_job(32'h4000_0000, 32'h0000_0000, 25'd8);
    tick(10);
    @(negedge clk);
    chk("credit_hs4",   32'(hs_cnt - hs0), 32'd4);
    chk("credit_valid", 32'(rd_req_valid_o), 32'd0);
    @(posedge clk); #1;
    man_pulse(8'd16);
    tick(6);
    chk("credit_hs5", 32'(hs_cnt - hs0), 32'd5);
    for (int i = 0; i < 7; i++) begin
      man_pulse(8'd16);
      tick(3);
    end
    wait_done("credit_done", 50);
    chk("credit_hs8", 32'(hs_cnt - hs0), 32'd8);
    chk("credit_comp", comp_bytes_o, 32'd128);
    chk("credit_wr",   wr_addr_o, 32'h0000_0080);

    // Backpressure
    rd_req_ready_i = 1'b0;
    exp_addr_q.push_back(32'h0000_5000);
    hs0 = hs_cnt;
    start_job(32'h0000_5000, 32'h0000_0100, 25'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", 32'(rd_req_valid_o), 32'd1);
      chk("bp_addr",  rd_req_addr_o, 32'h0000_5000);
      @(posedge clk); #1;
    end
    rd_req_ready_i = 1'b1;
    tick(3);
    chk("bp_hs",    32'(hs_cnt - hs0), 32'd1);
    chk("bp_valid_low", 32'(rd_req_valid_o), 32'd0);
    man_pulse(8'd128);
    wait_done("bp_done", 20);
    chk("bp_wr",   wr_addr_o, 32'h0000_0180);
    chk("bp_comp", comp_bytes_o, 32'h0000_0080);

    // Zero length
    hs0 = hs_cnt;
    start_job(32'h0000_6000, 32'h0000_0000, 25'd0);
    @(negedge clk);
    chk("zero_done",  32'(done_o), 32'd1);
    chk("zero_state", 32'(dut.state_q), 32'(IDLE));
    @(posedge clk); #1;
    tick(5);
    chk("zero_hs", 32'(hs_cnt - hs0), 32'd0);

    // Start ignored while running
    auto_en = 1'b1; auto_size = 8'd32;
    exp_addr_q.push_back(32'h3000_0000);
    exp_addr_q.push_back(32'h3000_0080);
    hs0 = hs_cnt;
    start_job(32'h3000_0000, 32'h0000_0050, 25'd2);
    start_job(32'h7000_0000, 32'h0000_0000, 25'd5);
    wait_done("ign_done", 50);
    chk("ign_wr",   wr_addr_o, 32'h0000_0090);
    chk("ign_comp", comp_bytes_o, 32'h0000_0040);
    tick(4);
    chk("ign_hs",   32'(hs_cnt - hs0), 32'd2);

    // Address wrap
    auto_size = 8'd8;
    exp_addr_q.push_back(32'hFFFF_FF80);
    exp_addr_q.push_back(32'h0000_0000);
    start_job(32'hFFFF_FFC0, 32'h0000_1000, 25'd2);
    wait_done("wrap_done", 50);
    chk("wrap_comp", comp_bytes_o, 32'd16);
    chk("wrap_wr",   wr_addr_o, 32'h0000_1010);
    chk("wrap_q",    32'(exp_addr_q.size()), 32'd0);
    auto_en = 1'b0;

    // Reset while draining
    exp_addr_q.push_back(32'h8000_0000);
    start_job(32'h8000_0000, 32'h0000_0010, 25'd1);
    tick(3);
    @(negedge clk);
    chk("drain_state", 32'(dut.state_q), 32'(DRAIN));
    chk("drain_done",  32'(done_o), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    @(negedge clk);
    chk("mrst_state", 32'(dut.state_q), 32'(IDLE));
    chk("mrst_valid", 32'(rd_req_valid_o), 32'd0);
    chk("mrst_addr",  rd_req_addr_o, 32'd0);
    chk("mrst_wr",    wr_addr_o, 32'd0);
    chk("mrst_comp",  comp_bytes_o, 32'd0);
    chk("mrst_done",  32'(done_o), 32'd0);
    @(posedge clk); #1;
    auto_en = 1'b1; auto_size = 8'd100;
    exp_addr_q.push_back(32'h9000_0000);
    start_job(32'h9000_0000, 32'h0000_0020, 25'd1);
    wait_done("post_rst_done", 30);
    chk("post_rst_wr", wr_addr_o, 32'h0000_0084);
    auto_en = 1'b0;

    // Simultaneous issue and completion
    rd_req_ready_i = 1'b0;
    exp_addr_q.push_back(32'h0000_0000);
    exp_addr_q.push_back(32'h0000_0080);
    exp_addr_q.push_back(32'h0000_0100);
    hs0 = hs_cnt;
    start_job(32'h0000_0000, 32'h0000_0200, 25'd3);
    rd_req_ready_i = 1'b1;
    tick(1);
    rd_req_ready_i = 1'b0;
    tick(2);
    @(negedge clk);
    chk("sim_out_pre", 32'(dut.u_credit.cnt_o), 32'd1);
    @(posedge clk); #1;
    rd_req_ready_i = 1'b1;
    man_pulse(8'd128);
    tick(1);
    rd_req_ready_i = 1'b0;
    @(negedge clk);
    chk("sim_out_post", 32'(dut.u_credit.cnt_o), 32'd1);
    chk("sim_wr",       wr_addr_o, 32'h0000_0280);
    chk("sim_comp",     comp_bytes_o, 32'h0000_0080);
    chk("sim_hs",       32'(hs_cnt - hs0), 32'd2);
    @(posedge clk); #1;
    tick(2);
    chk("sim_wr_once", wr_addr_o, 32'h0000_0280);
    rd_req_ready_i = 1'b1;
    tick(3);
    man_pulse(8'd128);
    tick(2);
    man_pulse(8'd128);
    wait_done("sim_done", 20);
    chk("sim_wr_final",   wr_addr_o, 32'h0000_0380);
    chk("sim_comp_final", comp_bytes_o, 32'h0000_0180);
    chk("sim_q", 32'(exp_addr_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
